// File: rtl/lif_pkg.sv
// ============================================================================
//  Module   : lif_pkg
//  Brief    : Default widths for the LIF neuron array and a saturating adder
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lif_pkg;

    localparam int c_N_NEURONS  = 4;
    localparam int c_IN_W       = 4;
    localparam int c_STATE_W    = 8;
    localparam int c_REFRAC_W   = 3;
    localparam int c_FIFO_DEPTH = 4;

    // 8-bit add that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage : lif_pkg

`default_nettype wire

// File: rtl/lif_neuron.sv
// ============================================================================
//  Module   : lif_neuron
//  Brief    : One leaky integrate-and-fire neuron with refractory counter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron
    import lif_pkg::*;
#(
    parameter int IN_W     = c_IN_W,
    parameter int STATE_W  = c_STATE_W,
    parameter int REFRAC_W = c_REFRAC_W
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_step,
    input  logic [IN_W-1:0]     i_cur,
    input  logic [STATE_W-1:0]  i_threshold,
    input  logic [2:0]          i_leak_shift,
    input  logic [REFRAC_W-1:0] i_refrac_cycles,
    output logic [STATE_W-1:0]  o_state,
    output logic                o_fire,   // combinational: fires on this step
    output logic                o_spike   // registered spike pulse
);

    logic [STATE_W-1:0]  r_state;
    logic [REFRAC_W-1:0] r_rcnt;
    logic                r_spike;
    logic [STATE_W-1:0]  w_leak;
    logic [STATE_W:0]    w_sum;
    logic [STATE_W-1:0]  w_nxt;
    logic                w_refrac;
    logic                w_fire;

    // Leak, integrate with one guard bit, saturate, compare to threshold
    always_comb begin
        w_leak   = (i_leak_shift == 3'd0) ? '0 : (r_state >> i_leak_shift);
        w_sum    = {1'b0, r_state} - {1'b0, w_leak}
                 + {{(STATE_W + 1 - IN_W){1'b0}}, i_cur};
        w_nxt    = w_sum[STATE_W] ? '1 : w_sum[STATE_W-1:0];
        w_refrac = (r_rcnt != '0);
        w_fire   = i_step && !w_refrac && (w_nxt >= i_threshold);
    end

    // Membrane, refractory counter and spike pulse update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_rcnt  <= '0;
            r_spike <= 1'b0;
        end else begin
            r_spike <= w_fire;
            if (i_step) begin
                if (w_refrac) begin
                    r_rcnt  <= r_rcnt - 1'b1;
                    r_state <= '0;
                end else if (w_fire) begin
                    r_state <= '0;
                    r_rcnt  <= i_refrac_cycles;
                end else begin
                    r_state <= w_nxt;
                end
            end
        end
    end

    assign o_state = r_state;
    assign o_fire  = w_fire;
    assign o_spike = r_spike;

endmodule : lif_neuron

`default_nettype wire

// File: rtl/lif_neuron_array_aer.sv
// ============================================================================
//  Module   : lif_neuron_array_aer
//  Brief    : Array of LIF neurons whose spikes are serialised into an
//             address-event stream through a small show-ahead FIFO
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron_array_aer
    import lif_pkg::*;
#(
    parameter  int N_NEURONS  = c_N_NEURONS,
    parameter  int IN_W       = c_IN_W,
    parameter  int STATE_W    = c_STATE_W,
    parameter  int REFRAC_W   = c_REFRAC_W,
    parameter  int FIFO_DEPTH = c_FIFO_DEPTH,
    localparam int ADDR_W     = $clog2(N_NEURONS)
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step,
    input  logic [N_NEURONS*IN_W-1:0] ext_input,
    input  logic [STATE_W-1:0]        threshold,
    input  logic [2:0]                leak_shift,
    input  logic [REFRAC_W-1:0]       refrac_cycles,
    input  logic [ADDR_W-1:0]         mon_sel,
    output logic [N_NEURONS-1:0]      spike,
    output logic [STATE_W-1:0]        mon_state,
    output logic                      aer_valid,
    output logic [ADDR_W-1:0]         aer_addr,
    input  logic                      aer_ready,
    output logic [7:0]                drop_cnt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [N_NEURONS-1:0] w_fire;
    logic [N_NEURONS-1:0] w_spike;
    logic [STATE_W-1:0]   w_state [N_NEURONS];

    logic [N_NEURONS-1:0] r_pend;
    logic [ADDR_W-1:0]    r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [7:0]           r_drop_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic [ADDR_W-1:0]    w_enc_idx;
    logic [N_NEURONS-1:0] w_clr;
    logic [N_NEURONS-1:0] w_drop;
    logic [7:0]           w_drop_num;

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            lif_neuron #(
                .IN_W     (IN_W),
                .STATE_W  (STATE_W),
                .REFRAC_W (REFRAC_W)
            ) u_neuron (
                .clk             (clk),
                .rst             (reset),
                .i_step          (step),
                .i_cur           (ext_input[gi*IN_W +: IN_W]),
                .i_threshold     (threshold),
                .i_leak_shift    (leak_shift),
                .i_refrac_cycles (refrac_cycles),
                .o_state         (w_state[gi]),
                .o_fire          (w_fire[gi]),
                .o_spike         (w_spike[gi])
            );
        end
    endgenerate

    // Priority encode the pending mask, decide push/pop and count drops.
    // A bit being pushed this cycle is free to be re-set by a new spike,
    // so it does not count as a drop.
    always_comb begin
        w_enc_idx = '0;
        w_clr     = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_enc_idx = ADDR_W'(i);
            end
        end
        w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
        w_empty = (r_count == '0);
        w_pop   = !w_empty && aer_ready;
        w_push  = (|r_pend) && (!w_full || w_pop);
        if (w_push) begin
            w_clr[w_enc_idx] = 1'b1;
        end
        w_drop     = w_fire & r_pend & ~w_clr;
        w_drop_num = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_drop_num = w_drop_num + {7'd0, w_drop[i]};
        end
    end

    // Pending mask, FIFO storage/pointers and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_pend     <= (r_pend & ~w_clr) | w_fire;
            r_drop_cnt <= sat_add8(r_drop_cnt, w_drop_num);
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_enc_idx;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Monitor mux over the neuron membrane registers
    always_comb begin
        mon_state = '0;
        if (int'(mon_sel) < N_NEURONS) begin
            mon_state = w_state[mon_sel];
        end
    end

    assign spike     = w_spike;
    assign aer_valid = !w_empty;
    assign aer_addr  = r_fifo[r_rd_ptr];
    assign drop_cnt  = r_drop_cnt;

endmodule : lif_neuron_array_aer

`default_nettype wire

// File: tb/tb_lif_neuron_array_aer.sv
// ============================================================================
//  Module   : tb_lif_neuron_array_aer
//  Brief    : Self-checking bench for lif_neuron_array_aer with a
//             behavioural reference model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_neuron_array_aer;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int SW = 8;
    localparam int RW = 3;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            step = 1'b0;
    logic [N*IW-1:0] ext_input = '0;
    logic [SW-1:0]   threshold = '0;
    logic [2:0]      leak_shift = '0;
    logic [RW-1:0]   refrac_cycles = '0;
    logic [1:0]      mon_sel = '0;
    logic [N-1:0]    spike;
    logic [SW-1:0]   mon_state;
    logic            aer_valid;
    logic [1:0]      aer_addr;
    logic            aer_ready = 1'b0;
    logic [7:0]      drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_st [N];
    int m_rc [N];
    bit m_pend [N];
    int m_q [$];
    int m_drop;
    int m_spike;

    lif_neuron_array_aer #(
        .N_NEURONS  (N),
        .IN_W       (IW),
        .STATE_W    (SW),
        .REFRAC_W   (RW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .step          (step),
        .ext_input     (ext_input),
        .threshold     (threshold),
        .leak_shift    (leak_shift),
        .refrac_cycles (refrac_cycles),
        .mon_sel       (mon_sel),
        .spike         (spike),
        .mon_state     (mon_state),
        .aer_valid     (aer_valid),
        .aer_addr      (aer_addr),
        .aer_ready     (aer_ready),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        bit fire [N];
        bit pop, push;
        int enc, cur, nx, lk;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_rc[i] = 0; m_pend[i] = 0;
            end
            m_q.delete();
            m_drop  = 0;
            m_spike = 0;
            return;
        end
        pop = (m_q.size() > 0) && aer_ready;
        enc = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) enc = i;
        push = (enc >= 0) && ((m_q.size() < FD) || pop);
        for (int i = 0; i < N; i++) begin
            fire[i] = 0;
            if (step) begin
                if (m_rc[i] > 0) begin
                    m_rc[i]--;
                    m_st[i] = 0;
                end else begin
                    cur = int'(ext_input[i*IW +: IW]);
                    lk  = (leak_shift == 0) ? 0 : (m_st[i] >> leak_shift);
                    nx  = m_st[i] - lk + cur;
                    if (nx > 255) nx = 255;
                    if (nx >= int'(threshold)) begin
                        fire[i] = 1; m_st[i] = 0; m_rc[i] = int'(refrac_cycles);
                    end else begin
                        m_st[i] = nx;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (fire[i] && m_pend[i] && !(push && enc == i) && m_drop < 255) m_drop++;
        if (push) m_pend[enc] = 0;
        m_spike = 0;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                m_pend[i] = 1;
                m_spike   = m_spike | (1 << i);
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(enc);
    endtask

    task automatic compare_all();
        check_val("spike", int'(spike), m_spike);
        check_val("aer_valid", int'(aer_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) check_val("aer_addr", int'(aer_addr), m_q[0]);
        check_val("drop_cnt", int'(drop_cnt), m_drop);
        check_val("mon_state", int'(mon_state), m_st[mon_sel]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; step = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic config_set(input int thr, input int ls, input int rc, input int rdy);
        threshold     = SW'(thr);
        leak_shift    = 3'(ls);
        refrac_cycles = RW'(rc);
        aer_ready     = rdy[0];
    endtask

    initial begin
        int exp1 [7] = '{3, 6, 9, 0, 0, 0, 3};
        int exp2 [5] = '{8, 4, 2, 1, 1};

        // reset state
        do_reset();
        check_val("rst_spike", int'(spike), 0);
        check_val("rst_valid", int'(aer_valid), 0);
        check_val("rst_addr", int'(aer_addr), 0);
        check_val("rst_drop", int'(drop_cnt), 0);
        check_val("rst_mon", int'(mon_state), 0);

        // integrate, fire, refractory hold
        config_set(10, 0, 2, 1);
        mon_sel = 2'd0; ext_input = 16'h0003;
        for (int k = 0; k < 7; k++) begin
            step = 1'b1;
            tick();
            check_val("t1_state", int'(mon_state), exp1[k]);
            if (k == 3) check_val("t1_spike", int'(spike[0]), 1);
        end
        step = 1'b0;
        tick(); tick();

        // leak decay
        do_reset();
        config_set(200, 1, 0, 1);
        ext_input = 16'h0008;
        for (int k = 0; k < 5; k++) begin
            step = 1'b1;
            tick();
            check_val("t2_state", int'(mon_state), exp2[k]);
            check_val("t2_spike", int'(spike), 0);
            ext_input = '0;
        end
        step = 1'b0;

        // saturation at the top of the range
        do_reset();
        config_set(255, 0, 0, 1);
        ext_input = 16'h000E;
        step = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) check_val("t3_252", int'(mon_state), 252);
        end
        check_val("t3_fire", int'(spike[0]), 1);
        check_val("t3_zero", int'(mon_state), 0);
        step = 1'b0;

        // simultaneous spikes stream in ascending order
        do_reset();
        config_set(1, 0, 0, 1);
        ext_input = 16'h1111;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_val("t4_spike", int'(spike), 15);
        check_val("t4_lat", int'(aer_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("t4_valid", int'(aer_valid), 1);
            check_val("t4_addr", int'(aer_addr), k);
        end
        tick();
        check_val("t4_done", int'(aer_valid), 0);

        // back-to-back steps with a stalled consumer
        do_reset();
        config_set(0, 0, 0, 0);
        ext_input = '0;
        step = 1'b1;
        tick(); tick();
        step = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_val("t5_drop", int'(drop_cnt), 3);
        check_val("t5_valid", int'(aer_valid), 1);
        check_val("t5_head", int'(aer_addr), 0);
        aer_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // reset with events queued
        do_reset();
        config_set(0, 0, 0, 0);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_val("t6_pre", int'(aer_valid), 1);
        do_reset();
        check_val("t6_valid", int'(aer_valid), 0);
        check_val("t6_drop", int'(drop_cnt), 0);
        check_val("t6_spike", int'(spike), 0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset         = ($urandom_range(0, 99) == 0);
            step          = ($urandom_range(0, 9) < 6);
            ext_input     = N*IW'($urandom);
            threshold     = ($urandom_range(0, 9) == 0) ? SW'(0) : SW'($urandom_range(1, 70));
            leak_shift    = 3'($urandom_range(0, 7));
            refrac_cycles = RW'($urandom_range(0, 7));
            mon_sel       = 2'($urandom_range(0, 3));
            aer_ready     = ($urandom_range(0, 9) < 6);
            tick();
        end

        // final reset clears every membrane
        do_reset();
        for (int i = 0; i < N; i++) begin
            mon_sel = 2'(i);
            #1;
            check_val("final_mon", int'(mon_state), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lif_neuron_array_aer

`default_nettype wire
